// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the mem_responder slice.
//   state_t      - responder FSM states (IDLE, WAIT, RESP)
//   BYTE_W       - byte-lane width in bits
//   WORD_BYTES   - bytes per stored word
//   CNT_W        - wait-state counter width
//   word_parity  - per-byte even parity of a data word
// Optional feature macro: MEM_RESPONDER_PARITY_EN (word_parity is used only then).

package mem_resp_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // One bit per byte lane; the bit makes the lane's total number of ones even.
    function automatic logic [WORD_BYTES-1:0] word_parity(input logic [WORD_W-1:0] w);
        logic [WORD_BYTES-1:0] p;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            p[i] = ^w[i*BYTE_W +: BYTE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: DEPTH_WORDS x 32-bit storage.
//   clk            in   rising-edge clock
//   addr           in   word index
//   we             in   per-byte write enables (synchronous write)
//   wdata          in   write data
//   inj_parity_err in   (MEM_RESPONDER_PARITY_EN only) invert stored parity of byte 0 on write
//   re             in   read enable; rdata/rperr update on the next edge
//   rdata          out  registered read data
//   rperr          out  registered parity mismatch of the read word (0 without parity)
// Optional feature macro: MEM_RESPONDER_PARITY_EN adds a 4-bit even-parity field per word.
// Storage has no reset; contents survive the responder reset.

module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_BYTES-1:0]          we,
    input  logic [WORD_W-1:0]              wdata,
`ifdef MEM_RESPONDER_PARITY_EN
    input  logic                           inj_parity_err,
`endif
    input  logic                           re,
    output logic [WORD_W-1:0]              rdata,
    output logic                           rperr
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (we[i]) begin
                mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

`ifdef MEM_RESPONDER_PARITY_EN
    logic [WORD_BYTES-1:0] par [DEPTH_WORDS];
    logic [WORD_BYTES-1:0] wpar;

    // Injection flips lane 0 only, so a later load sees exactly one bad lane.
    always_comb begin
        wpar    = word_parity(wdata);
        wpar[0] = wpar[0] ^ inj_parity_err;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (we[i]) begin
                par[addr][i] <= wpar[i];
            end
        end
        if (re) begin
            rperr <= |(word_parity(mem[addr]) ^ par[addr]);
        end
    end
`else
    assign rperr = 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// mem_responder: target side of the CPU data-memory interface.
// Accepts one load/store at a time, waits WAIT_CYCLES, performs the access on the
// internal word array, then presents the response until the CPU accepts it.
//   clk            in   rising-edge clock
//   clr            in   asynchronous active-low reset
//   req_valid      in   request present
//   req_ready      out  responder can accept a request
//   req_write      in   1 = store, 0 = load
//   req_addr       in   byte address
//   req_wdata      in   store data
//   req_be         in   byte enables (bit i covers wdata[8i+7:8i])
//   inj_parity_err in   (MEM_RESPONDER_PARITY_EN only) corrupt byte-0 parity of a store
//   rsp_valid      out  response present
//   rsp_ready      in   CPU accepts the response
//   rsp_rdata      out  load data; 0 for stores and faults
//   rsp_err        out  misaligned / out-of-range access, or parity error on loads
// Optional feature macro: MEM_RESPONDER_PARITY_EN.

module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [WORD_W-1:0]     req_wdata,
    input  logic [WORD_BYTES-1:0] req_be,
`ifdef MEM_RESPONDER_PARITY_EN
    input  logic                  inj_parity_err,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  wr_q;
    logic [31:0]           addr_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [WORD_BYTES-1:0] be_q;
    logic                  rsp_load_q;  // response carries array read data
    logic                  rsp_err_q;   // alignment / range fault of this response

    logic                  acc_write;
    logic [31:0]           acc_addr;
    logic [WORD_W-1:0]     acc_wdata;
    logic [WORD_BYTES-1:0] acc_be;
    logic                  enter_resp;
    logic                  fault;
    logic [WORD_BYTES-1:0] mem_we;
    logic                  mem_re;
    logic [WORD_W-1:0]     mem_rdata;
    logic                  mem_rperr;

    // With WAIT_CYCLES == 0 the access commits on the acceptance edge itself, so the
    // live request fields are used in IDLE and the captured copy everywhere else.
    always_comb begin
        if (state == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_write = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    always_comb begin
        enter_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == '0));
        fault      = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
        mem_we     = (enter_resp && acc_write && !fault) ? acc_be : '0;
        mem_re     = enter_resp && !acc_write && !fault;
    end

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk           (clk),
        .addr          (acc_addr[AW+1:2]),
        .we            (mem_we),
        .wdata         (acc_wdata),
`ifdef MEM_RESPONDER_PARITY_EN
        .inj_parity_err(inj_parity_err),
`endif
        .re            (mem_re),
        .rdata         (mem_rdata),
        .rperr         (mem_rperr)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            cnt        <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rsp_load_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_load_q <= mem_re;
                            rsp_err_q  <= fault;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_load_q <= mem_re;
                        rsp_err_q  <= fault;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state      <= IDLE;
                        rsp_valid  <= 1'b0;
                        req_ready  <= 1'b1;
                        rsp_load_q <= 1'b0;
                        rsp_err_q  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Array read register is only loaded when entering RESP, so it is stable
    // for the whole response; non-load responses show zero.
    assign rsp_rdata = rsp_load_q ? mem_rdata : '0;
    assign rsp_err   = rsp_err_q | (rsp_load_q & mem_rperr);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder.
// Instance 0: DEPTH_WORDS=1024, WAIT_CYCLES=1.  Instance 1: DEPTH_WORDS=16, WAIT_CYCLES=3.
// Optional feature macro: MEM_RESPONDER_PARITY_EN enables the parity sequence.

module tb_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        inj       [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    mem_responder #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(1)
    ) dut0 (
        .clk           (clk),
        .clr           (clr[0]),
        .req_valid     (req_valid[0]),
        .req_ready     (req_ready[0]),
        .req_write     (req_write[0]),
        .req_addr      (req_addr[0]),
        .req_wdata     (req_wdata[0]),
        .req_be        (req_be[0]),
`ifdef MEM_RESPONDER_PARITY_EN
        .inj_parity_err(inj[0]),
`endif
        .rsp_valid     (rsp_valid[0]),
        .rsp_ready     (rsp_ready[0]),
        .rsp_rdata     (rsp_rdata[0]),
        .rsp_err       (rsp_err[0])
    );

    mem_responder #(
        .DEPTH_WORDS(16),
        .WAIT_CYCLES(3)
    ) dut1 (
        .clk           (clk),
        .clr           (clr[1]),
        .req_valid     (req_valid[1]),
        .req_ready     (req_ready[1]),
        .req_write     (req_write[1]),
        .req_addr      (req_addr[1]),
        .req_wdata     (req_wdata[1]),
        .req_be        (req_be[1]),
`ifdef MEM_RESPONDER_PARITY_EN
        .inj_parity_err(inj[1]),
`endif
        .rsp_valid     (rsp_valid[1]),
        .rsp_ready     (rsp_ready[1]),
        .rsp_rdata     (rsp_rdata[1]),
        .rsp_err       (rsp_err[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        check({tag, " req_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, " rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata[d], 32'd0);
        check({tag, " rsp_err"},   32'(rsp_err[d]),   32'd0);
    endtask

    // One complete transaction with rsp_ready held high. lat counts negedges after
    // the acceptance edge up to and including the first one that shows rsp_valid.
    task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic inj_v,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        @(negedge clk);
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        inj[d]       = inj_v;
        guard = 0;
        while (!req_ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("req_ready timeout", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request fields; they must not matter after acceptance.
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'h0000_0020;
        req_wdata[d] = 32'hFFFF_FFFF;
        req_be[d]    = 4'hF;
        req_write[d] = ~wr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[d] && lat < 50);
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk);
        #1;
        inj[d] = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0022, 32'h0,         4'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0024, 32'h1234_5678, 4'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 32'hAA00_0000, 4'h8, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hAA02_0304, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1});

        for (int d = 0; d < 2; d++) begin
            clr[d]       = 1'b0;
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
            inj[d]       = 1'b0;
            rsp_ready[d] = 1'b1;
        end

        repeat (2) @(negedge clk);
        check_reset_outputs(0, "reset0");
        check_reset_outputs(1, "reset1");
        clr[0] = 1'b1;
        clr[1] = 1'b1;

        // Table-driven transactions on the WAIT_CYCLES=1 instance.
        for (int i = 0; i < vecs.size(); i++) begin
            do_txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, rd, er, lat);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
        end

        // Back-pressure: load 0x10 held for 5 cycles while a second load waits.
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h0000_0010;
        req_valid[0] = 1'b1;
        check("bp idle req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_addr[0] = 32'h0000_0020;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rsp_valid[0] && guard < 50);
        check("bp first rdata", rsp_rdata[0], 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d rsp_valid", k), 32'(rsp_valid[0]), 32'd1);
            check($sformatf("bp hold%0d rdata", k), rsp_rdata[0], 32'hDEAD_BEEF);
            check($sformatf("bp hold%0d req_ready", k), 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp after hs rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp after hs req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        check("bp second accepted", 32'(req_ready[0]), 32'd0);
        req_valid[0] = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rsp_valid[0] && guard < 50);
        check("bp second rdata", rsp_rdata[0], 32'h11BB_33DD);
        check("bp second latency", 32'(guard), 32'd1);
        @(posedge clk);

`ifdef MEM_RESPONDER_PARITY_EN
        do_txn(0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 1'b1, rd, er, lat);
        check("par inj store err", 32'(er), 32'd0);
        do_txn(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("par bad load rdata", rd, 32'hA5A5_A5A5);
        check("par bad load err", 32'(er), 32'd1);
        do_txn(0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 1'b0, rd, er, lat);
        do_txn(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("par clean load rdata", rd, 32'hA5A5_A5A5);
        check("par clean load err", 32'(er), 32'd0);
`endif

        // WAIT_CYCLES=3 instance: latency, range boundary, reset in WAIT.
        do_txn(1, 1'b1, 32'h0000_0030, 32'h1357_2468, 4'hF, 1'b0, rd, er, lat);
        check("w3 store latency", 32'(lat), 32'd4);
        do_txn(1, 1'b0, 32'h0000_0030, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("w3 load rdata", rd, 32'h1357_2468);
        check("w3 load latency", 32'(lat), 32'd4);
        do_txn(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("w3 range err", 32'(er), 32'd1);
        check("w3 range rdata", rd, 32'h0);

        @(negedge clk);
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h0000_0030;
        req_wdata[1] = 32'hFFFF_FFFF;
        req_be[1]    = 4'hF;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("w3 in wait req_ready", 32'(req_ready[1]), 32'd0);
        clr[1] = 1'b0;
        #1;
        check_reset_outputs(1, "w3 clr");
        @(negedge clk);
        check_reset_outputs(1, "w3 clr held");
        clr[1] = 1'b1;
        do_txn(1, 1'b0, 32'h0000_0030, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check("w3 after reset rdata", rd, 32'h1357_2468);
        check("w3 after reset err", 32'(er), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
